reset_pulse_gen: RTL and testbench
==================================

Name: reset_pulse_gen

Overview:
- Reset request source for the board: turns a push-button, a software request and its own power-on reset into a clean, timed, active-low reset pulse `rst_out_n`.
- `rst_out_n` feeds the downstream reset synchronizer/delay stage. This block produces the reset; that stage consumes it.
- Debounces the button, enforces a minimum pulse width and a hold-off, and records the cause of the last reset.

Parameters:
- CLOCK_FREQ_HZ, 10000000, clock frequency; cycles per us = CLOCK_FREQ_HZ/1000000 (integer divide).
- DEBOUNCE_US, 10000, time the button must be held low before it counts as a press.
- PULSE_US, 100, width of the `rst_out_n` low pulse.
- HOLDOFF_US, 1000, minimum time after a pulse before a new request is accepted.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high (power-on / PLL-not-locked).
- btn_n  in  1  asynchronous push-button, active low; synchronized internally.
- sw_req  in  1  software reset request, 1-cycle pulse, synchronous to clock.
- sw_ack  out  1  1-cycle pulse: sw_req accepted.
- rst_out_n  out  1  generated reset, active low, registered.
- busy  out  1  high whenever state != IDLE.
- cause  out  2  source of the last pulse: 0 POR, 1 BUTTON, 2 SW, 3 reserved.
- rst_count  out  8  number of BUTTON+SW pulses issued; saturates at 255.

Behaviour:
- Cycle counts: X_CNT = X_US * (CLOCK_FREQ_HZ/1000000). Any result below 1 is forced to 1. Counter width is $clog2(max count + 1).
- While rst=1:
  - rst_out_n=0, sw_ack=0, cause=0, rst_count=0.
  - Synchronizer flops = 1 (released).
  - Counter = 0, state = ASSERT.
  - So releasing rst yields exactly one full POR pulse.
- Button path: 2-flop synchronizer, giving btn_s. The 2-cycle sync latency precedes the debounce.
- States: IDLE, DEBOUNCE, ASSERT, HOLDOFF.
- IDLE:
  - rst_out_n=1.
  - sw_req=1 → ASSERT. cause<=2, sw_ack=1 next cycle, counter cleared.
  - Else btn_s=0 → DEBOUNCE, counter cleared.
  - sw_req has priority over the button in the same cycle.
- DEBOUNCE:
  - Counter increments each cycle btn_s=0.
  - btn_s=1 before DEBOUNCE_CNT consecutive low cycles → IDLE. No pulse, cause unchanged.
  - Counter reaches DEBOUNCE_CNT → ASSERT, cause<=1.
  - sw_req is ignored here (no ack).
- ASSERT:
  - rst_out_n=0 for exactly PULSE_CNT cycles; first low cycle is the cycle after entry decision.
  - Then → HOLDOFF, rst_out_n=1.
  - rst_count increments (saturating) on entry for causes 1 and 2 only.
- HOLDOFF:
  - rst_out_n=1. Counter runs to HOLDOFF_CNT.
  - Exit to IDLE only when the count is done AND btn_s=1. A held button therefore never retriggers.
  - sw_req is ignored.
- sw_ack asserts only on an accepted request. Requests dropped in non-IDLE states are not queued.
- rst asserted mid-pulse or mid-debounce restarts a POR pulse from zero; cause becomes 0.
- Glitch on btn_n shorter than 2 cycles may be absorbed by the synchronizer. Any shorter-than-debounce low is rejected.

Decomposition:
- Package reset_gen_pkg:
  - state enum.
  - cause codes CAUSE_POR/CAUSE_BTN/CAUSE_SW.
  - function us_to_cycles(us, freq) with the min-1 clamp.
- Sub-module bit_sync_2ff: parameterised reset value, used for btn_n.
- FSM, counter and status registers stay in reset_pulse_gen.

Test Plan:
- Bench parameters for all tests: CLOCK_FREQ_HZ=1000000, DEBOUNCE_US=4, PULSE_US=3, HOLDOFF_US=5.
- Power-on: rst high 5 cycles, then low → rst_out_n low exactly 3 cycles after release, then high; cause=0; busy low once HOLDOFF ends (5 cycles).
- Software request: sw_req 1 cycle in IDLE → next cycle sw_ack=1, rst_out_n low 3 cycles, cause=2, rst_count=1. Second sw_req during HOLDOFF → no ack, no pulse.
- Button bounce: btn_n low 3 cycles (post-sync), then high → no pulse, back to IDLE. Then held low 20 cycles → one pulse after 2+4 cycles, cause=1, no second pulse while held; IDLE only after release.
- Simultaneous: btn_n falling with sw_req in the same IDLE cycle → SW wins, cause=2, single pulse.
- Reset mid-operation and saturation: rst during ASSERT restarts a 3-cycle POR pulse, cause=0, rst_count=0. 300 SW requests spaced apart → rst_count=255.

Source files
------------

// File: rtl/reset_gen_pkg.sv
// Shared types and helpers for the board reset pulse generator.
// Holds FSM states, reset cause codes and the us-to-cycles conversion.
package reset_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ASSERT,
    ST_HOLDOFF
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_SW   = 2'd2,
    CAUSE_RSVD = 2'd3
  } cause_e;

  localparam int unsigned HZ_PER_MHZ = 1000000;
  localparam int unsigned RST_CNT_W  = 8;

  // Durations shorter than one clock still need one cycle.
  function automatic int unsigned us_to_cycles(
    input int unsigned us,
    input int unsigned freq
  );
    int unsigned c;
    c = us * (freq / HZ_PER_MHZ);
    if (c < 1) c = 1;
    return c;
  endfunction

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [RST_CNT_W-1:0] sat_inc(
    input logic [RST_CNT_W-1:0] v
  );
    logic [RST_CNT_W-1:0] r;
    r = v;
    if (v != {RST_CNT_W{1'b1}}) r = v + RST_CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/reset_pulse_gen_if.sv
// Request/status bundle of the reset pulse generator.
// Inputs: btn_n, sw_req. Outputs: sw_ack, rst_out_n, busy, cause, rst_count.
interface reset_pulse_gen_if;
  import reset_gen_pkg::*;

  logic                 btn_n;
  logic                 sw_req;
  logic                 sw_ack;
  logic                 rst_out_n;
  logic                 busy;
  cause_e               cause;
  logic [RST_CNT_W-1:0] rst_count;

  modport master (
    output btn_n,
    output sw_req,
    input  sw_ack,
    input  rst_out_n,
    input  busy,
    input  cause,
    input  rst_count
  );

  modport slave (
    input  btn_n,
    input  sw_req,
    output sw_ack,
    output rst_out_n,
    output busy,
    output cause,
    output rst_count
  );

endinterface

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clock, rst (sync, active high), d (async in), q (synced out).
module bit_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d;
  logic meta_q;
  logic sync_d;
  logic sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_pulse_gen.sv
// Timed active-low reset pulse from POR, debounced button or software.
// Ports: clock, rst (sync, active high), bus (reset_pulse_gen_if.slave).
module reset_pulse_gen
  import reset_gen_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 10000000,
  parameter int unsigned DEBOUNCE_US   = 10000,
  parameter int unsigned PULSE_US      = 100,
  parameter int unsigned HOLDOFF_US    = 1000
) (
  input  logic                clock,
  input  logic                rst,
  reset_pulse_gen_if.slave    bus
);

  localparam int unsigned DEB_CNT =
    us_to_cycles(DEBOUNCE_US, CLOCK_FREQ_HZ);
  localparam int unsigned PUL_CNT =
    us_to_cycles(PULSE_US, CLOCK_FREQ_HZ);
  localparam int unsigned HLD_CNT =
    us_to_cycles(HOLDOFF_US, CLOCK_FREQ_HZ);
  localparam int unsigned MAX_CNT =
    max3(DEB_CNT, PUL_CNT, HLD_CNT);
  localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

  // Terminal values: the decision is taken on the last counted cycle.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PUL_CNT - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HLD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_s;

  state_e               state_d,     state_q;
  logic [CNT_W-1:0]     cnt_d,       cnt_q;
  cause_e               cause_d,     cause_q;
  logic [RST_CNT_W-1:0] rst_count_d, rst_count_q;
  logic                 sw_ack_d,    sw_ack_q;
  logic                 rst_out_n_d, rst_out_n_q;
  logic                 busy_d,      busy_q;

  // Released (high) while in reset so no false press is seen.
  bit_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_btn_sync (
    .clock (clock),
    .rst   (rst),
    .d     (bus.btn_n),
    .q     (btn_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    rst_count_d = rst_count_q;
    sw_ack_d    = 1'b0;

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (bus.sw_req) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          cause_d     = CAUSE_SW;
          sw_ack_d    = 1'b1;
          rst_count_d = sat_inc(rst_count_q);
        end else if (!btn_s) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end

      (state_q == ST_DEBOUNCE): begin
        if (btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          cause_d     = CAUSE_BTN;
          rst_count_d = sat_inc(rst_count_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      (state_q == ST_ASSERT): begin
        if (cnt_q == PUL_LAST) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      (state_q == ST_HOLDOFF): begin
        // Counter parks at its last value until the button is up.
        if (cnt_q == HLD_LAST) begin
          if (btn_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they line up with it.
    rst_out_n_d = (state_d != ST_ASSERT);
    busy_d      = (state_d != ST_IDLE);
  end

  // Reset parks the FSM at the start of a fresh POR pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      cause_q     <= CAUSE_POR;
      rst_count_q <= '0;
      sw_ack_q    <= 1'b0;
      rst_out_n_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      rst_count_q <= rst_count_d;
      sw_ack_q    <= sw_ack_d;
      rst_out_n_q <= rst_out_n_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sw_ack    = sw_ack_q;
  assign bus.rst_out_n = rst_out_n_q;
  assign bus.busy      = busy_q;
  assign bus.cause     = cause_q;
  assign bus.rst_count = rst_count_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed bench for reset_pulse_gen with a pulse scoreboard.
// Expected pulses are queued at stimulus time and checked when they end.
module tb_reset_pulse_gen;

  typedef struct {
    logic [1:0] cause;
    logic [7:0] cnt;
    int         width;
  } exp_t;

  logic clock = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;
  int low_len = 0;
  int model_cnt = 0;
  exp_t q[$];

  reset_pulse_gen_if bus ();

  reset_pulse_gen #(
    .CLOCK_FREQ_HZ (1000000),
    .DEBOUNCE_US   (4),
    .PULSE_US      (3),
    .HOLDOFF_US    (5)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [1:0] c,
                              input logic [7:0] n);
    exp_t e;
    e.cause = c;
    e.cnt   = n;
    e.width = 3;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (bus.busy !== 1'b0) chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  // Pulse monitor, sampled 2 time units after each rising edge.
  // The cycle right after the last reset edge is already pulse cycle 1.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rst) begin
        low_len = 1;
      end else if (bus.rst_out_n === 1'b0) begin
        low_len++;
      end else if (low_len != 0) begin
        chk("pulse_queued", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_width", low_len, e.width);
          chk("pulse_cause", 32'(bus.cause), 32'(e.cause));
          chk("pulse_count", 32'(bus.rst_count), 32'(e.cnt));
        end
        low_len = 0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.btn_n  = 1'b1;
    bus.sw_req = 1'b0;

    // Power-on
    tick(5);
    chk("rst_out_n_rst", 32'(bus.rst_out_n), 0);
    chk("sw_ack_rst", 32'(bus.sw_ack), 0);
    chk("cause_rst", 32'(bus.cause), 0);
    chk("count_rst", 32'(bus.rst_count), 0);
    chk("busy_rst", 32'(bus.busy), 1);
    expect_pulse(2'd0, 8'd0);
    rst = 1'b0;
    tick(1);
    chk("por_low1", 32'(bus.rst_out_n), 0);
    tick(1);
    chk("por_low2", 32'(bus.rst_out_n), 0);
    tick(1);
    chk("por_high", 32'(bus.rst_out_n), 1);
    chk("por_holdoff_busy", 32'(bus.busy), 1);
    tick(4);
    chk("por_holdoff_end_busy", 32'(bus.busy), 1);
    tick(1);
    chk("por_idle", 32'(bus.busy), 0);

    // Software request, then a dropped one in holdoff
    tick(1);
    bus.sw_req = 1'b1;
    model_cnt = 1;
    expect_pulse(2'd2, 8'(model_cnt));
    tick(1);
    bus.sw_req = 1'b0;
    chk("sw_ack", 32'(bus.sw_ack), 1);
    chk("sw_low", 32'(bus.rst_out_n), 0);
    chk("sw_cause", 32'(bus.cause), 2);
    chk("sw_count", 32'(bus.rst_count), 1);
    tick(1);
    chk("sw_ack_once", 32'(bus.sw_ack), 0);
    tick(2);
    chk("sw_pulse_end", 32'(bus.rst_out_n), 1);
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    chk("holdoff_no_ack", 32'(bus.sw_ack), 0);
    chk("holdoff_no_pulse", 32'(bus.rst_out_n), 1);
    chk("holdoff_count", 32'(bus.rst_count), 1);
    wait_idle();

    // Button bounce: three synchronized low cycles
    tick(1);
    bus.btn_n = 1'b0;
    tick(3);
    bus.btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bounce_no_pulse", 32'(bus.rst_out_n), 1);
    end
    chk("bounce_idle", 32'(bus.busy), 0);

    // Button held for 20 cycles
    bus.btn_n = 1'b0;
    model_cnt = 2;
    expect_pulse(2'd1, 8'(model_cnt));
    tick(6);
    chk("btn_not_yet", 32'(bus.rst_out_n), 1);
    tick(1);
    chk("btn_low", 32'(bus.rst_out_n), 0);
    chk("btn_cause", 32'(bus.cause), 1);
    chk("btn_count", 32'(bus.rst_count), 2);
    tick(13);
    chk("btn_held_busy", 32'(bus.busy), 1);
    chk("btn_held_high", 32'(bus.rst_out_n), 1);
    bus.btn_n = 1'b1;
    tick(2);
    chk("btn_release_busy", 32'(bus.busy), 1);
    tick(1);
    chk("btn_release_idle", 32'(bus.busy), 0);

    // Button low and sw_req seen by the FSM in the same cycle
    tick(1);
    bus.btn_n = 1'b0;
    tick(2);
    bus.sw_req = 1'b1;
    model_cnt = 3;
    expect_pulse(2'd2, 8'(model_cnt));
    tick(1);
    bus.sw_req = 1'b0;
    bus.btn_n  = 1'b1;
    chk("simul_ack", 32'(bus.sw_ack), 1);
    chk("simul_cause", 32'(bus.cause), 2);
    wait_idle();
    tick(8);
    chk("simul_single", 32'(bus.busy), 0);

    // Reset during an active pulse
    bus.sw_req = 1'b1;
    tick(1);
    bus.sw_req = 1'b0;
    chk("mid_ack", 32'(bus.sw_ack), 1);
    tick(1);
    expect_pulse(2'd0, 8'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_low", 32'(bus.rst_out_n), 0);
    chk("mid_cause", 32'(bus.cause), 0);
    chk("mid_count", 32'(bus.rst_count), 0);
    chk("mid_ack_clr", 32'(bus.sw_ack), 0);
    model_cnt = 0;
    wait_idle();

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      wait_idle();
      bus.sw_req = 1'b1;
      if (model_cnt < 255) model_cnt++;
      expect_pulse(2'd2, 8'(model_cnt));
      tick(1);
      bus.sw_req = 1'b0;
    end
    wait_idle();
    tick(2);
    chk("sat_count", 32'(bus.rst_count), 255);
    chk("queue_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
